// File: rtl/regfile_2p_if.sv
// -----------------------------------------------------------------------------
// regfile_2p_if
//   Bus bundle for the two-port register file.
//
//   Write side : WrEn, WrAddr, WrData, WrProt
//   Read side  : RdEn, RdAddr -> RdData, RdData_Valid
//   Status     : Addr_Err, Wr_Err (and Par_Err when REGFILE_2P_PARITY_EN is set)
//   Export     : REG_OUT, live contents of registers 0..NOUT-1
//
//   modport master : the agent issuing reads/writes
//   modport slave  : the register file
//
//   Optional macro: REGFILE_2P_PARITY_EN adds the Par_Err signal.
// -----------------------------------------------------------------------------
interface regfile_2p_if #(
  parameter int WIDTH     = 8,
  parameter int ADDR_SIZE = 4,
  parameter int NOUT      = 4
);
  logic                  WrEn;
  logic [ADDR_SIZE-1:0]  WrAddr;
  logic [WIDTH-1:0]      WrData;
  logic [NOUT-1:0]       WrProt;
  logic                  RdEn;
  logic [ADDR_SIZE-1:0]  RdAddr;
  logic [WIDTH-1:0]      RdData;
  logic                  RdData_Valid;
  logic                  Addr_Err;
  logic                  Wr_Err;
  logic [NOUT*WIDTH-1:0] REG_OUT;
`ifdef REGFILE_2P_PARITY_EN
  logic                  Par_Err;
`endif

  modport master (
    output WrEn, WrAddr, WrData, WrProt, RdEn, RdAddr,
    input  RdData, RdData_Valid, Addr_Err, Wr_Err, REG_OUT
`ifdef REGFILE_2P_PARITY_EN
    , input Par_Err
`endif
  );

  modport slave (
    input  WrEn, WrAddr, WrData, WrProt, RdEn, RdAddr,
    output RdData, RdData_Valid, Addr_Err, Wr_Err, REG_OUT
`ifdef REGFILE_2P_PARITY_EN
    , output Par_Err
`endif
  );
endinterface

// File: rtl/regfile_2p.sv
// -----------------------------------------------------------------------------
// regfile_2p
//   Parametrised register file with one write port and one read port usable
//   in the same cycle. Reads have one cycle of latency and are write-first
//   when an accepted write targets the same address. Writes to protected
//   low registers or to addresses >= DEPTH are dropped and flagged.
//   Registers 0..NOUT-1 are exported continuously on REG_OUT.
//
//   Ports:
//     CLK  - clock, everything updates on the rising edge
//     RST  - synchronous active-low reset
//     bus  - regfile_2p_if.slave (write/read ports, status pulses, REG_OUT)
//
//   Optional macro: REGFILE_2P_PARITY_EN stores an even-parity bit per entry
//   and drives bus.Par_Err alongside RdData_Valid on a stored-parity mismatch.
// -----------------------------------------------------------------------------
module regfile_2p #(
  parameter int                    WIDTH     = 8,
  parameter int                    DEPTH     = 16,
  parameter int                    ADDR_SIZE = 4,
  parameter int                    NOUT      = 4,
  parameter logic [NOUT*WIDTH-1:0] RST_VALS  = {8'h08, 8'h20, 8'h00, 8'h00}
) (
  input logic         CLK,
  input logic         RST,
  regfile_2p_if.slave bus
);

`ifdef REGFILE_2P_PARITY_EN
  localparam int EW = WIDTH + 1;  // data plus parity bit at the top
`else
  localparam int EW = WIDTH;
`endif

  // Reset contents of entry i, with its parity bit when parity is stored.
  function automatic logic [EW-1:0] rst_entry(input int i);
    logic [WIDTH-1:0] v;
    v = '0;
    if (i < NOUT) v = RST_VALS[i*WIDTH +: WIDTH];
`ifdef REGFILE_2P_PARITY_EN
    return {^v, v};
`else
    return v;
`endif
  endfunction

  logic [EW-1:0] mem [DEPTH];

  logic          wr_in_range;
  logic          rd_in_range;
  logic          prot_hit;
  logic          wr_ok;
  logic          bypass;
  logic [EW-1:0] rd_word;
  logic [EW-1:0] wr_word;

  assign wr_in_range = 32'(bus.WrAddr) < 32'(DEPTH);
  assign rd_in_range = 32'(bus.RdAddr) < 32'(DEPTH);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    prot_hit = 1'b0;
    for (int i = 0; i < NOUT; i++)
      if (bus.WrAddr == ADDR_SIZE'(i) && bus.WrProt[i]) prot_hit = 1'b1;
  end

  // Explicit mux keeps out-of-range addresses from indexing past the array.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.RdAddr == ADDR_SIZE'(i)) rd_word = mem[i];
  end

  assign wr_ok  = bus.WrEn && wr_in_range && !prot_hit;
  assign bypass = wr_ok && bus.RdEn && (bus.WrAddr == bus.RdAddr);

`ifdef REGFILE_2P_PARITY_EN
  assign wr_word = {^bus.WrData, bus.WrData};
`else
  assign wr_word = bus.WrData;
`endif

  // NOTE: the storage is plain flops, not a RAM macro, because every entry
  // has a defined reset value; so the whole array is reset here.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= rst_entry(i);
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_ok && bus.WrAddr == ADDR_SIZE'(i)) mem[i] <= wr_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      bus.RdData       <= '0;
      bus.RdData_Valid <= 1'b0;
      bus.Addr_Err     <= 1'b0;
      bus.Wr_Err       <= 1'b0;
    end else begin
      bus.RdData_Valid <= bus.RdEn;
      if (bus.RdEn) begin
        if (!rd_in_range) bus.RdData <= '0;
        else if (bypass)  bus.RdData <= bus.WrData;
        else              bus.RdData <= rd_word[WIDTH-1:0];
      end
      // One pulse even if both ports are out of range together.
      bus.Addr_Err <= (bus.WrEn && !wr_in_range) || (bus.RdEn && !rd_in_range);
      bus.Wr_Err   <= bus.WrEn && wr_in_range && prot_hit;
    end
  end

`ifdef REGFILE_2P_PARITY_EN
  // Even parity over data+parity must be 0; bypassed and out-of-range reads
  // never report, since their data does not come from storage.
  always_ff @(posedge CLK) begin
    if (!RST) bus.Par_Err <= 1'b0;
    else      bus.Par_Err <= bus.RdEn && rd_in_range && !bypass && (^rd_word);
  end
`endif

  for (genvar g = 0; g < NOUT; g++) begin : g_out
    assign bus.REG_OUT[g*WIDTH +: WIDTH] = mem[g][WIDTH-1:0];
  end

endmodule

// File: tb/tb_regfile_2p.sv
// -----------------------------------------------------------------------------
// tb_regfile_2p
//   Directed bench for regfile_2p built with DEPTH=12 so that out-of-range
//   addresses (12..15) exist on the 4-bit address ports. Inputs change 1 ns
//   after a rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_regfile_2p;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 12;
  localparam int ADDR_SIZE = 4;
  localparam int NOUT      = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_2p_if #(.WIDTH(WIDTH), .ADDR_SIZE(ADDR_SIZE), .NOUT(NOUT)) bus ();

  regfile_2p #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_SIZE(ADDR_SIZE), .NOUT(NOUT),
    .RST_VALS({8'h08, 8'h20, 8'h00, 8'h00})
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.WrEn   = 1'b0;
    bus.RdEn   = 1'b0;
    bus.WrAddr = '0;
    bus.WrData = '0;
    bus.RdAddr = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.WrEn   = 1'b1;
    bus.WrAddr = a;
    bus.WrData = d;
  endtask

  task automatic rd(input logic [3:0] a);
    bus.RdEn   = 1'b1;
    bus.RdAddr = a;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.WrProt = '0;
    idle();
    cyc();
    cyc();

    // Reset state
    check("rst_rddata", 32'(bus.RdData), 32'h00);
    check("rst_valid", 32'(bus.RdData_Valid), 32'h0);
    check("rst_addr_err", 32'(bus.Addr_Err), 32'h0);
    check("rst_wr_err", 32'(bus.Wr_Err), 32'h0);
    check("rst_reg_out", bus.REG_OUT, 32'h0820_0000);
`ifdef REGFILE_2P_PARITY_EN
    check("rst_par_err", 32'(bus.Par_Err), 32'h0);
`endif
    rst_n = 1'b1;

    // Read of a never-written in-range register
    rd(4'd9);
    cyc();
    idle();
    check("rd9_data", 32'(bus.RdData), 32'h00);
    check("rd9_valid", 32'(bus.RdData_Valid), 32'h1);
    check("rd9_addr_err", 32'(bus.Addr_Err), 32'h0);

    // Write then read next cycle; then hold
    wr(4'd5, 8'hA5);
    cyc();
    idle();
    check("wr5_no_valid", 32'(bus.RdData_Valid), 32'h0);
    rd(4'd5);
    cyc();
    idle();
    check("rd5_data", 32'(bus.RdData), 32'hA5);
    check("rd5_valid", 32'(bus.RdData_Valid), 32'h1);
    cyc();
    check("hold_data", 32'(bus.RdData), 32'hA5);
    check("hold_valid", 32'(bus.RdData_Valid), 32'h0);

    // Write-first bypass on the same address
    wr(4'd7, 8'h3C);
    rd(4'd7);
    cyc();
    idle();
    check("byp7_data", 32'(bus.RdData), 32'h3C);
    check("byp7_valid", 32'(bus.RdData_Valid), 32'h1);
    check("byp7_wr_err", 32'(bus.Wr_Err), 32'h0);

    // Protection mask has no effect above NOUT
    bus.WrProt = 4'b1111;
    wr(4'd6, 8'h77);
    rd(4'd6);
    cyc();
    idle();
    check("byp6_prot_irrel", 32'(bus.RdData), 32'h77);
    check("byp6_wr_err", 32'(bus.Wr_Err), 32'h0);

    // Protected register 1: write dropped, old data read
    bus.WrProt = 4'b0010;
    wr(4'd1, 8'h99);
    rd(4'd1);
    cyc();
    idle();
    check("prot1_data", 32'(bus.RdData), 32'h00);
    check("prot1_wr_err", 32'(bus.Wr_Err), 32'h1);
    check("prot1_reg_out", bus.REG_OUT, 32'h0820_0000);
    cyc();
    check("prot1_wr_err_pulse", 32'(bus.Wr_Err), 32'h0);

    // Unprotected low register write shows on REG_OUT after the edge
    wr(4'd0, 8'h11);
    cyc();
    idle();
    check("reg0_reg_out", bus.REG_OUT, 32'h0820_0011);
    bus.WrProt = 4'b0000;

    // Read and write at different addresses are independent
    wr(4'd8, 8'h42);
    rd(4'd5);
    cyc();
    idle();
    check("indep_rd5", 32'(bus.RdData), 32'hA5);

    // Back-to-back reads
    rd(4'd8);
    cyc();
    check("b2b_rd8", 32'(bus.RdData), 32'h42);
    check("b2b_rd8_valid", 32'(bus.RdData_Valid), 32'h1);
    rd(4'd7);
    cyc();
    check("b2b_rd7", 32'(bus.RdData), 32'h3C);
    check("b2b_rd7_valid", 32'(bus.RdData_Valid), 32'h1);
    rd(4'd6);
    cyc();
    idle();
    check("b2b_rd6", 32'(bus.RdData), 32'h77);
    check("b2b_rd6_valid", 32'(bus.RdData_Valid), 32'h1);

    // Last in-range address
    wr(4'd11, 8'h6B);
    cyc();
    idle();
    check("wr11_addr_err", 32'(bus.Addr_Err), 32'h0);
    rd(4'd11);
    cyc();
    idle();
    check("rd11_data", 32'(bus.RdData), 32'h6B);

    // Out-of-range write
    wr(4'd13, 8'hFF);
    cyc();
    idle();
    check("wr13_addr_err", 32'(bus.Addr_Err), 32'h1);
    check("wr13_wr_err", 32'(bus.Wr_Err), 32'h0);
    check("wr13_reg_out", bus.REG_OUT, 32'h0820_0011);
    cyc();
    check("wr13_addr_err_pulse", 32'(bus.Addr_Err), 32'h0);

    // Out-of-range read
    rd(4'd15);
    cyc();
    idle();
    check("rd15_data", 32'(bus.RdData), 32'h00);
    check("rd15_valid", 32'(bus.RdData_Valid), 32'h1);
    check("rd15_addr_err", 32'(bus.Addr_Err), 32'h1);

    // Out-of-range write and read at the same address: no bypass
    wr(4'd12, 8'h5A);
    rd(4'd12);
    cyc();
    idle();
    check("oor_same_data", 32'(bus.RdData), 32'h00);
    check("oor_same_addr_err", 32'(bus.Addr_Err), 32'h1);
    cyc();
    check("oor_same_pulse", 32'(bus.Addr_Err), 32'h0);

    // Reset overriding a concurrent read
    wr(4'd2, 8'h55);
    cyc();
    idle();
    check("wr2_reg_out", bus.REG_OUT, 32'h0855_0011);
    rst_n = 1'b0;
    rd(4'd2);
    cyc();
    idle();
    check("rst_rd_data", 32'(bus.RdData), 32'h00);
    check("rst_rd_valid", 32'(bus.RdData_Valid), 32'h0);
    check("rst_rd_reg_out", bus.REG_OUT, 32'h0820_0000);
    rst_n = 1'b1;

    // Normal operation after reset release; array was reset too
    rd(4'd5);
    cyc();
    check("post_rst_rd5", 32'(bus.RdData), 32'h00);
    check("post_rst_valid", 32'(bus.RdData_Valid), 32'h1);
    rd(4'd3);
    cyc();
    idle();
    check("post_rst_rd3", 32'(bus.RdData), 32'h08);

`ifdef REGFILE_2P_PARITY_EN
    // Corrupt stored data bit 0 of entry 4 and read it back
    wr(4'd4, 8'h0F);
    cyc();
    idle();
    dut.mem[4][0] = ~dut.mem[4][0];
    rd(4'd4);
    cyc();
    idle();
    check("par_bad_err", 32'(bus.Par_Err), 32'h1);
    check("par_bad_valid", 32'(bus.RdData_Valid), 32'h1);
    rd(4'd5);
    cyc();
    idle();
    check("par_clean_err", 32'(bus.Par_Err), 32'h0);
    // Bypassed read of a fresh write never flags
    wr(4'd4, 8'h01);
    rd(4'd4);
    cyc();
    idle();
    check("par_byp_err", 32'(bus.Par_Err), 32'h0);
`endif

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
